ddma_multichannel: RTL and testbench

- Parametrised successor of the single-channel DDMA: NUM_CHANNELS independent command slots share one transfer engine.
- A round-robin arbiter picks the next pending channel. The engine reads memory words and serialises them into NoC flits with a header.
- Each channel has its own status code and interrupt, cleared by software.
- Sits between the TCD/CPU side (command/status) and the memory port plus the NoC local port.

---
 rtl/ddma_multichannel.sv | 240 ++++++++++++++++++++++++
 tb/tb_ddma_multichannel.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddma_multichannel.sv
// Multichannel DDMA: NUM_CHANNELS command slots share one memory-to-NoC
// transfer engine. A round-robin arbiter picks the next pending channel. The
// engine emits a header flit holding the payload flit count, then reads one
// word at a time and serialises it into flits, least-significant flit first.
//
// Engine states:
//   state    | meaning
//   S_IDLE   | scan channels from rr_ptr for a PENDING one
//   S_HEADER | present header flit (payload flit count) until credit
//   S_READ   | one-cycle memory read request at cur_addr
//   S_WAIT   | wait for read data, latch it
//   S_SEND   | emit FPW flits of the held word, one per credited cycle
//   S_DONE   | one cycle after the last flit; channel already marked DONE
module ddma_multichannel #(
  parameter int MEMORY_BUS_WIDTH = 32,
  parameter int FLIT_WIDTH       = 16,
  parameter int NUM_CHANNELS     = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [MEMORY_BUS_WIDTH-3:0]   addr_in,
  input  logic [MEMORY_BUS_WIDTH-3:0]   nbytes_in,
  input  logic [NUM_CHANNELS-1:0]       cmd_in,
  input  logic [NUM_CHANNELS-1:0]       irq_ack_in,
  output logic [3*NUM_CHANNELS-1:0]     status_out,
  output logic [NUM_CHANNELS-1:0]       irq_out,
  output logic [MEMORY_BUS_WIDTH-3:0]   mem_addr_out,
  output logic                          mem_rd_out,
  input  logic [MEMORY_BUS_WIDTH-1:0]   mem_data_in,
  input  logic                          mem_valid_in,
  output logic [FLIT_WIDTH-1:0]         flit_out,
  output logic                          tx_out,
  input  logic                          credit_in
);

  localparam int AW    = MEMORY_BUS_WIDTH - 2;
  localparam int FPW   = MEMORY_BUS_WIDTH / FLIT_WIDTH;
  localparam int BPW   = MEMORY_BUS_WIDTH / 8;
  localparam int CW    = $clog2(NUM_CHANNELS);
  localparam int CNT_W = (FPW > 1) ? $clog2(FPW) : 1;
  localparam int PW    = 2 * MEMORY_BUS_WIDTH;

  localparam logic [2:0] ST_IDLE = 3'b000;
  localparam logic [2:0] ST_PEND = 3'b001;
  localparam logic [2:0] ST_BUSY = 3'b010;
  localparam logic [2:0] ST_DONE = 3'b011;
  localparam logic [2:0] ST_ERR  = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE, S_HEADER, S_READ, S_WAIT, S_SEND, S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [2:0]            ch_status [NUM_CHANNELS];
  logic [AW-1:0]         ch_addr   [NUM_CHANNELS];
  logic [AW-1:0]         ch_words  [NUM_CHANNELS];
  logic [FLIT_WIDTH-1:0] ch_plen   [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] irq_q, irq_set;

  logic [CW-1:0]         rr_ptr, cur_ch;
  logic [AW-1:0]         cur_addr, words_left;
  logic [FLIT_WIDTH-1:0] cur_plen;
  logic [MEMORY_BUS_WIDTH-1:0] data_buf;
  logic [CNT_W-1:0]      flit_left;

  logic          acc_valid, acc_err, acc_found;
  logic [CW-1:0] acc_ch;
  logic          grant_valid, grant;
  logic [CW-1:0] grant_ch, scan_idx;
  int            scan;
  logic          done_go;

  logic [AW:0]   nb_ext, words_full;
  logic [PW-1:0] plen_full;

  // Word and flit counts of the command on the input bus; oversize payloads
  // cannot be described by a one-flit header and are rejected.
  always_comb begin
    nb_ext     = {1'b0, nbytes_in} + (AW+1)'(BPW - 1);
    words_full = nb_ext / (AW+1)'(BPW);
    plen_full  = PW'(words_full) * PW'(FPW);
    acc_err    = (nbytes_in == '0) || (plen_full > PW'({FLIT_WIDTH{1'b1}}));
  end

  // Command accept: lowest set strobe wins; dropped if that channel is in flight.
  always_comb begin
    acc_valid = 1'b0;
    acc_found = 1'b0;
    acc_ch    = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (cmd_in[i] && !acc_found) begin
        acc_found = 1'b1;
        acc_ch    = CW'(i);
        acc_valid = (ch_status[i] != ST_PEND) && (ch_status[i] != ST_BUSY);
      end
    end
  end

  // Round-robin scan for a PENDING channel starting at rr_ptr.
  always_comb begin
    grant_valid = 1'b0;
    grant_ch    = '0;
    scan        = 0;
    scan_idx    = '0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      scan = int'(rr_ptr) + k;
      if (scan >= NUM_CHANNELS) scan = scan - NUM_CHANNELS;
      scan_idx = CW'(scan);
      if (!grant_valid && ch_status[scan_idx] == ST_PEND) begin
        grant_valid = 1'b1;
        grant_ch    = scan_idx;
      end
    end
  end

  assign grant   = (state == S_IDLE) && grant_valid;
  assign done_go = (state == S_SEND) && credit_in && (flit_left == '0)
                   && (words_left == AW'(1));

  // Engine state register.
  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Engine next-state and Moore outputs.
  always_comb begin
    state_nxt    = state;
    tx_out       = 1'b0;
    mem_rd_out   = 1'b0;
    flit_out     = '0;
    mem_addr_out = '0;
    case (state)
      S_IDLE:   if (grant_valid) state_nxt = S_HEADER;
      S_HEADER: begin
        tx_out   = 1'b1;
        flit_out = cur_plen;
        if (credit_in) state_nxt = S_READ;
      end
      S_READ: begin
        mem_rd_out   = 1'b1;
        mem_addr_out = cur_addr;
        state_nxt    = S_WAIT;
      end
      S_WAIT:   if (mem_valid_in) state_nxt = S_SEND;
      S_SEND: begin
        tx_out   = 1'b1;
        flit_out = data_buf[FLIT_WIDTH-1:0];
        if (credit_in && flit_left == '0)
          state_nxt = (words_left == AW'(1)) ? S_DONE : S_READ;
      end
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Engine datapath: grant capture, address walk, word buffer and flit counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr     <= '0;
      cur_ch     <= '0;
      cur_addr   <= '0;
      words_left <= '0;
      cur_plen   <= '0;
      data_buf   <= '0;
      flit_left  <= '0;
    end else begin
      case (state)
        S_IDLE: if (grant_valid) begin
          cur_ch     <= grant_ch;
          cur_addr   <= ch_addr[grant_ch];
          words_left <= ch_words[grant_ch];
          cur_plen   <= ch_plen[grant_ch];
          rr_ptr     <= (grant_ch == CW'(NUM_CHANNELS - 1)) ? '0 : grant_ch + CW'(1);
        end
        S_READ: cur_addr <= cur_addr + AW'(1);
        S_WAIT: if (mem_valid_in) begin
          data_buf  <= mem_data_in;
          flit_left <= CNT_W'(FPW - 1);
        end
        S_SEND: if (credit_in) begin
          data_buf  <= data_buf >> FLIT_WIDTH;
          flit_left <= flit_left - CNT_W'(1);
          if (flit_left == '0) words_left <= words_left - AW'(1);
        end
        default: ;
      endcase
    end
  end

  // Per-channel command slots and status; accept, grant and completion never
  // target the same channel in one cycle because they require distinct states.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        ch_status[i] <= ST_IDLE;
        ch_addr[i]   <= '0;
        ch_words[i]  <= '0;
        ch_plen[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (acc_valid && acc_ch == CW'(i)) begin
          ch_status[i] <= acc_err ? ST_ERR : ST_PEND;
          ch_addr[i]   <= addr_in;
          ch_words[i]  <= words_full[AW-1:0];
          ch_plen[i]   <= plen_full[FLIT_WIDTH-1:0];
        end else if (grant && grant_ch == CW'(i)) begin
          ch_status[i] <= ST_BUSY;
        end else if (done_go && cur_ch == CW'(i)) begin
          ch_status[i] <= ST_DONE;
        end
      end
    end
  end

  // Interrupt sources: rejected command or transfer completion.
  always_comb begin
    irq_set = '0;
    for (int i = 0; i < NUM_CHANNELS; i++)
      irq_set[i] = (acc_valid && acc_err && acc_ch == CW'(i)) ||
                   (done_go && cur_ch == CW'(i));
  end

  // Interrupt flags: ack clears, a simultaneous set wins.
  always_ff @(posedge clock) begin
    if (reset) irq_q <= '0;
    else       irq_q <= (irq_q & ~irq_ack_in) | irq_set;
  end

  assign irq_out = irq_q;

  // Pack per-channel status codes onto the flat status bus.
  always_comb begin
    status_out = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) status_out[3*i +: 3] = ch_status[i];
  end

endmodule

// File: tb/tb_ddma_multichannel.sv
// Directed bench for ddma_multichannel with default parameters.
// Memory model answers each read one cycle later with a word derived from
// its address: {4'hB, addr[11:0], 4'hA, addr[11:0]}.
module tb_ddma_multichannel;

  logic        clock;
  logic        reset;
  logic [29:0] addr_in, nbytes_in, mem_addr_out;
  logic [3:0]  cmd_in, irq_ack_in, irq_out;
  logic [11:0] status_out;
  logic        mem_rd_out, mem_valid_in, tx_out, credit_in;
  logic [31:0] mem_data_in;
  logic [15:0] flit_out;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc;

  logic [15:0] fq[$], efq[$];
  logic [29:0] rq[$], erq[$];

  logic        rd_pend = 1'b0;
  logic [29:0] rd_pend_addr = '0;

  ddma_multichannel dut (
    .clock(clock), .reset(reset), .addr_in(addr_in), .nbytes_in(nbytes_in),
    .cmd_in(cmd_in), .irq_ack_in(irq_ack_in), .status_out(status_out),
    .irq_out(irq_out), .mem_addr_out(mem_addr_out), .mem_rd_out(mem_rd_out),
    .mem_data_in(mem_data_in), .mem_valid_in(mem_valid_in), .flit_out(flit_out),
    .tx_out(tx_out), .credit_in(credit_in)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [31:0] mem_word(input logic [29:0] a);
    return {4'hB, a[11:0], 4'hA, a[11:0]};
  endfunction

  // Memory: valid with data one cycle after a read request.
  initial begin
    mem_valid_in = 1'b0;
    mem_data_in  = '0;
    forever begin
      @(negedge clock);
      if (rd_pend) begin
        mem_valid_in = 1'b1;
        mem_data_in  = mem_word(rd_pend_addr);
      end else begin
        mem_valid_in = 1'b0;
      end
      rd_pend      = mem_rd_out;
      rd_pend_addr = mem_addr_out;
    end
  end

  // Monitor: log accepted flits and read addresses.
  initial begin
    forever begin
      @(negedge clock);
      if (tx_out && credit_in) fq.push_back(flit_out);
      if (mem_rd_out) rq.push_back(mem_addr_out);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  function automatic logic [2:0] st(input int ch);
    return status_out[3*ch +: 3];
  endfunction

  task automatic issue(input logic [3:0] mask, input logic [29:0] a, input logic [29:0] nb);
    cmd_in    = mask;
    addr_in   = a;
    nbytes_in = nb;
    tick(1);
    cmd_in    = '0;
  endtask

  task automatic wait_st(input int ch, input logic [2:0] code, input int budget, output int n);
    n = 0;
    while (st(ch) !== code && n < budget) begin
      tick(1);
      n++;
    end
  endtask

  task automatic wait_flits(input int count, input int budget);
    for (int i = 0; i < budget && fq.size() < count; i++) tick(1);
  endtask

  task automatic clear_q();
    fq.delete();
    rq.delete();
  endtask

  task automatic check_queues(input string tag);
    check({tag, "_nflits"}, fq.size(), efq.size());
    for (int i = 0; i < efq.size() && i < fq.size(); i++)
      check($sformatf("%s_flit%0d", tag, i), fq[i], efq[i]);
    check({tag, "_nreads"}, rq.size(), erq.size());
    for (int i = 0; i < erq.size() && i < rq.size(); i++)
      check($sformatf("%s_rd%0d", tag, i), rq[i], erq[i]);
  endtask

  initial begin
    reset = 1'b1; cmd_in = '0; irq_ack_in = '0; addr_in = '0; nbytes_in = '0;
    credit_in = 1'b1;
    tick(2);
    check("rst_status", status_out, 12'h000);
    check("rst_irq", irq_out, 4'h0);
    check("rst_tx", tx_out, 1'b0);
    check("rst_rd", mem_rd_out, 1'b0);
    check("rst_flit", flit_out, 16'h0000);
    check("rst_maddr", mem_addr_out, 30'h0);
    reset = 1'b0;
    tick(1);
    clear_q();

    // ch0, two words, exact latency
    issue(4'b0001, 30'h10, 30'd8);
    check("t1_pending", st(0), 3'b001);
    tick(1);
    check("t1_busy", st(0), 3'b010);
    check("t1_hdr_tx", tx_out, 1'b1);
    check("t1_hdr", flit_out, 16'h0004);
    wait_st(0, 3'b011, 50, cyc);
    check("t1_done", st(0), 3'b011);
    check("t1_cycles", cyc, 9);
    check("t1_irq", irq_out, 4'b0001);
    efq = '{16'h0004, 16'hA010, 16'hB010, 16'hA011, 16'hB011};
    erq = '{30'h10, 30'h11};
    check_queues("t1");
    irq_ack_in = 4'b0001; tick(1); irq_ack_in = '0;
    check("t1_irq_ack", irq_out, 4'b0000);

    // ch1, partial last word and single word
    clear_q();
    issue(4'b0010, 30'h20, 30'd5);
    wait_st(1, 3'b011, 60, cyc);
    check("t2a_done", st(1), 3'b011);
    efq = '{16'h0004, 16'hA020, 16'hB020, 16'hA021, 16'hB021};
    erq = '{30'h20, 30'h21};
    check_queues("t2a");
    irq_ack_in = 4'b0010; tick(1); irq_ack_in = '0;
    clear_q();
    issue(4'b0010, 30'h30, 30'd4);
    wait_st(1, 3'b011, 60, cyc);
    check("t2b_done", st(1), 3'b011);
    efq = '{16'h0002, 16'hA030, 16'hB030};
    erq = '{30'h30};
    check_queues("t2b");
    irq_ack_in = 4'b0010; tick(1); irq_ack_in = '0;

    // ch2, zero length
    clear_q();
    issue(4'b0100, 30'h55, 30'd0);
    check("t3_err", st(2), 3'b100);
    check("t3_irq", irq_out, 4'b0100);
    tick(5);
    check("t3_no_flits", fq.size(), 0);
    check("t3_no_reads", rq.size(), 0);
    irq_ack_in = 4'b0100; tick(1); irq_ack_in = '0;

    // simultaneous commands, queuing while busy, round-robin order
    clear_q();
    cmd_in = 4'b1001; addr_in = 30'h40; nbytes_in = 30'd4;
    tick(1);
    check("t4_ch0_pend", st(0), 3'b001);
    check("t4_ch3_ignored", st(3), 3'b000);
    cmd_in = 4'b1000; addr_in = 30'h50;
    tick(1);
    cmd_in = '0;
    check("t4_ch3_pend", st(3), 3'b001);
    check("t4_ch0_busy", st(0), 3'b010);
    wait_st(3, 3'b010, 60, cyc);
    check("t4_ch3_busy", st(3), 3'b010);
    check("t4_ch0_done", st(0), 3'b011);
    issue(4'b0010, 30'h60, 30'd4);
    issue(4'b0001, 30'h70, 30'd4);
    check("t4_ch1_pend", st(1), 3'b001);
    check("t4_ch0_rearm", st(0), 3'b001);
    check("t4_ch0_irq_kept", irq_out[0], 1'b1);
    wait_st(1, 3'b011, 100, cyc);
    check("t4_ch1_done", st(1), 3'b011);
    check("t4_irq", irq_out, 4'b1011);
    efq = '{16'h0002, 16'hA040, 16'hB040, 16'h0002, 16'hA050, 16'hB050,
            16'h0002, 16'hA070, 16'hB070, 16'h0002, 16'hA060, 16'hB060};
    erq = '{30'h40, 30'h50, 30'h70, 30'h60};
    check_queues("t4");
    irq_ack_in = 4'b1111; tick(1); irq_ack_in = '0;
    check("t4_irq_ack", irq_out, 4'b0000);

    // credit stall mid-word
    clear_q();
    issue(4'b0100, 30'h80, 30'd8);
    wait_flits(2, 50);
    check("t5_reach", fq.size(), 2);
    credit_in = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("t5_hold_flit%0d", k), flit_out, 16'hB080);
      check($sformatf("t5_hold_tx%0d", k), tx_out, 1'b1);
      tick(1);
    end
    check("t5_no_push", fq.size(), 2);
    credit_in = 1'b1;
    wait_st(2, 3'b011, 60, cyc);
    check("t5_done", st(2), 3'b011);
    efq = '{16'h0004, 16'hA080, 16'hB080, 16'hA081, 16'hB081};
    erq = '{30'h80, 30'h81};
    check_queues("t5");

    // reset during WAIT, then a normal transfer
    check("t6_irq_before", irq_out, 4'b0100);
    clear_q();
    issue(4'b0010, 30'h90, 30'd8);
    for (int i = 0; i < 50 && rq.size() < 1; i++) tick(1);
    check("t6_in_wait", rq.size(), 1);
    reset = 1'b1;
    tick(1);
    check("t6_status", status_out, 12'h000);
    check("t6_irq", irq_out, 4'h0);
    check("t6_tx", tx_out, 1'b0);
    check("t6_rd", mem_rd_out, 1'b0);
    check("t6_flit", flit_out, 16'h0000);
    check("t6_maddr", mem_addr_out, 30'h0);
    reset = 1'b0;
    tick(2);
    clear_q();
    issue(4'b0010, 30'hA0, 30'd4);
    wait_st(1, 3'b011, 60, cyc);
    check("t6_done", st(1), 3'b011);
    check("t6_irq_after", irq_out, 4'b0010);
    efq = '{16'h0002, 16'hA0A0, 16'hB0A0};
    erq = '{30'hA0};
    check_queues("t6");
    irq_ack_in = 4'b0010; tick(1); irq_ack_in = '0;

    // ack coincident with completion: set wins
    clear_q();
    issue(4'b0001, 30'hC0, 30'd4);
    wait_flits(2, 50);
    check("t7_last_flit", flit_out, 16'hB0C0);
    check("t7_busy", st(0), 3'b010);
    irq_ack_in = 4'b0001;
    tick(1);
    irq_ack_in = '0;
    check("t7_done", st(0), 3'b011);
    check("t7_irq_set_wins", irq_out[0], 1'b1);
    tick(1);
    check("t7_irq_held", irq_out[0], 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
